ex_stage: RTL and testbench
===========================

// Module: ex_stage
// PURPOSE
//  RV32I execute stage. Sits directly upstream of the memory stage and feeds it.
//  - Selects operands through forwarding muxes and runs the ALU.
//  - Resolves branches and jumps, and issues the cache request strobes one cycle
//    ahead of the memory stage.
//  - Registers the EX/MEM pipeline bundle, with a pipeline-wide advance enable
//    and a flush.
// PARAMETERS
//  BUBBLE_INST  32'h0000_0000  inst value loaded into the EX/MEM register on a flush or at reset
//  ALU_SEL_W    4              width of the ALU operation select
// PORTS
//  clk_i          in   1   clock
//  rst_ni         in   1   reset, synchronous, active-low
//  enable_i       in   1   pipeline advance; low while the cache stalls the processor
//  reset_i        in   1   flush; loads a bubble into EX/MEM when enable_i=1
//  pc_ex_i        in   32  PC of the instruction in EX
//  rs1_ex_i       in   32  register-file read data, source 1
//  rs2_ex_i       in   32  register-file read data, source 2
//  imm_ex_i       in   32  immediate, already sign-extended
//  inst_ex_i      in   32  instruction word
//  ASel_ex_i      in   1   operand A select: 0=rs1, 1=pc
//  BSel_ex_i      in   1   operand B select: 0=rs2, 1=imm
//  ALUSel_ex_i    in   4   ALU operation
//  BrUn_ex_i      in   1   unsigned branch compare
//  MemRW_ex_i     in   1   store instruction
//  WBSel_ex_i     in   2   writeback select (passed through)
//  RegWEn_ex_i    in   1   register write enable (passed through)
//  rsW_ex_i       in   5   destination register
//  fwdA_sel_i     in   2   forwarding select, source 1: 0=rs1_ex_i, 1=alu_mem_fwd_i, 2=wb_fwd_i, 3=rs1_ex_i
//  fwdB_sel_i     in   2   forwarding select, source 2: same encoding as fwdA_sel_i
//  alu_mem_fwd_i  in   32  ALU result currently held in the memory stage
//  wb_fwd_i       in   32  final writeback data
//  alu_mem_o      out  32  registered ALU result; this is the cache address
//  rs2_mem_o      out  32  registered forwarded rs2; this is the store data
//  pc4_mem_o      out  32  registered pc+4
//  MemRW_mem_o    out  1   registered store flag
//  WBSel_mem_o    out  2   registered writeback select
//  RegWEn_mem_o   out  1   registered register write enable
//  rsW_mem_o      out  5   registered destination register
//  inst_mem_o     out  32  registered instruction word
//  rd_request_o   out  1   comb: load in EX (opcode 7'b0000011) & enable_i & ~reset_i
//  MemRW_ex_o     out  1   comb: MemRW_ex_i & enable_i & ~reset_i (cache write request)
//  br_taken_o     out  1   comb: redirect the PC
//  pc_target_o    out  32  comb: redirect target
// BEHAVIOUR
//  - Reset (rst_ni=0 at a rising clk_i edge): all registered outputs become 0, except
//    inst_mem_o = BUBBLE_INST. Reset has priority over enable_i and reset_i, and
//    takes effect mid-stall.
//  - enable_i=1 & reset_i=1: same values as reset are loaded, giving a bubble
//    (RegWEn=0, MemRW=0).
//  - enable_i=1 & reset_i=0: EX/MEM loads the current EX values. Latency is 1 cycle.
//  - enable_i=0: every register holds, whatever the value of reset_i.
//    rd_request_o, MemRW_ex_o and br_taken_o are forced to 0.
//  - Operands:
//    - fa = fwd(rs1), fb = fwd(rs2).
//    - A = ASel ? pc : fa.
//    - B = BSel ? imm : fb.
//    - rs2_mem_o captures fb.
//  - ALU ops:
//    - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB (LUI).
//    - 11..15 produce 0.
//    - Shift amount is B[4:0].
//    - All arithmetic is modulo 2^32; overflow is ignored.
//  - Branch condition (opcode 7'b1100011), using funct3 and comparing fa against fb:
//    - 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
//    - LT and GE compare unsigned when BrUn=1.
//    - funct3 010 and 011 are never taken.
//  - JAL (7'b1101111) and JALR (7'b1100111) are always taken.
//  - br_taken_o = condition & enable_i & ~reset_i.
//  - pc_target_o:
//    - JALR: (fa + imm) & ~32'h1.
//    - Otherwise: pc + imm.
//    - Valid whenever br_taken_o=1.
//  - pc4_mem_o captures pc_ex_i + 4, wrapping at 2^32.
// CONFIGURATION
//  EX_FWD_EN defined:
//   - fwdA_sel_i and fwdB_sel_i select operands as listed under PORTS.
//  EX_FWD_EN undefined:
//   - fa = rs1_ex_i and fb = rs2_ex_i; the fwd select and fwd data ports are ignored.
//   - Hazards are then resolved entirely by stalling elsewhere.
//   - The port list is unchanged in both builds.
// TESTING
//  1. rs1=5, rs2=7, ADD, BSel=0, enable_i=1 -> next cycle alu_mem_o=12 and pc4_mem_o=pc+4.
//  2. SRA with A=32'h8000_0000 and B=33 (shamt=1) -> alu_mem_o=32'hC000_0000.
//     SLTU with A=1 and B=32'hFFFF_FFFF -> alu_mem_o=1.
//  3. Stall: enable_i=0 for 3 cycles with new EX inputs and reset_i=1 ->
//     EX/MEM outputs are unchanged, and rd_request_o, MemRW_ex_o and br_taken_o stay 0.
//  4. Flush: enable_i=1, reset_i=1 with a store in EX -> RegWEn_mem_o=0, MemRW_mem_o=0,
//     inst_mem_o=BUBBLE_INST, MemRW_ex_o=0.
//  5. BLTU with fa=1 and fb=32'hFFFF_FFFF -> br_taken_o=1 and pc_target_o=pc+imm.
//     Same operands with BLT -> br_taken_o=0.
//     JALR with rs1=32'h1001 and imm=2 -> pc_target_o=32'h1002.
//  6. EX_FWD_EN defined: fwdA_sel_i=1 with alu_mem_fwd_i=9, and fwdB_sel_i=2 with
//     wb_fwd_i=3, ADD -> 12.
//     EX_FWD_EN undefined, same stimulus -> rs1 + rs2.
//     rst_ni=0 mid-stall -> all registered outputs are 0.

Source files
------------

// File: rtl/ex_stage_if.sv
// EX -> MEM bundle plus the cache request strobes, driven by ex_stage (master)
// and consumed by the memory stage / cache (slave).
interface ex_stage_if;
    logic [31:0] alu_mem_o;
    logic [31:0] rs2_mem_o;
    logic [31:0] pc4_mem_o;
    logic        MemRW_mem_o;
    logic [1:0]  WBSel_mem_o;
    logic        RegWEn_mem_o;
    logic [4:0]  rsW_mem_o;
    logic [31:0] inst_mem_o;
    logic        rd_request_o;
    logic        MemRW_ex_o;

    modport master (
        output alu_mem_o, rs2_mem_o, pc4_mem_o, MemRW_mem_o, WBSel_mem_o,
               RegWEn_mem_o, rsW_mem_o, inst_mem_o, rd_request_o, MemRW_ex_o
    );

    modport slave (
        input  alu_mem_o, rs2_mem_o, pc4_mem_o, MemRW_mem_o, WBSel_mem_o,
               RegWEn_mem_o, rsW_mem_o, inst_mem_o, rd_request_o, MemRW_ex_o
    );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch resolution and the EX/MEM register.
// Build option: define EX_FWD_EN to enable the forwarding muxes (default: operands straight from the register file).
module ex_stage #(
    parameter logic [31:0] BUBBLE_INST = 32'h0000_0000,
    parameter int          ALU_SEL_W   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic                 reset_i,
    input  logic [31:0]          pc_ex_i,
    input  logic [31:0]          rs1_ex_i,
    input  logic [31:0]          rs2_ex_i,
    input  logic [31:0]          imm_ex_i,
    input  logic [31:0]          inst_ex_i,
    input  logic                 ASel_ex_i,
    input  logic                 BSel_ex_i,
    input  logic [ALU_SEL_W-1:0] ALUSel_ex_i,
    input  logic                 BrUn_ex_i,
    input  logic                 MemRW_ex_i,
    input  logic [1:0]           WBSel_ex_i,
    input  logic                 RegWEn_ex_i,
    input  logic [4:0]           rsW_ex_i,
    input  logic [1:0]           fwdA_sel_i,
    input  logic [1:0]           fwdB_sel_i,
    input  logic [31:0]          alu_mem_fwd_i,
    input  logic [31:0]          wb_fwd_i,
    ex_stage_if.master           mem_if,
    output logic                 br_taken_o,
    output logic [31:0]          pc_target_o
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [ALU_SEL_W-1:0] ALU_ADD  = ALU_SEL_W'(0);
    localparam logic [ALU_SEL_W-1:0] ALU_SUB  = ALU_SEL_W'(1);
    localparam logic [ALU_SEL_W-1:0] ALU_SLL  = ALU_SEL_W'(2);
    localparam logic [ALU_SEL_W-1:0] ALU_SLT  = ALU_SEL_W'(3);
    localparam logic [ALU_SEL_W-1:0] ALU_SLTU = ALU_SEL_W'(4);
    localparam logic [ALU_SEL_W-1:0] ALU_XOR  = ALU_SEL_W'(5);
    localparam logic [ALU_SEL_W-1:0] ALU_SRL  = ALU_SEL_W'(6);
    localparam logic [ALU_SEL_W-1:0] ALU_SRA  = ALU_SEL_W'(7);
    localparam logic [ALU_SEL_W-1:0] ALU_OR   = ALU_SEL_W'(8);
    localparam logic [ALU_SEL_W-1:0] ALU_AND  = ALU_SEL_W'(9);
    localparam logic [ALU_SEL_W-1:0] ALU_PASB = ALU_SEL_W'(10);

    logic [31:0] w_fa;
    logic [31:0] w_fb;
    logic [31:0] w_op_a;
    logic [31:0] w_op_b;
    logic [31:0] w_alu;
    logic [31:0] w_jalr_sum;
    logic [4:0]  w_shamt;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_lt;
    logic        w_cond;
    logic        w_go;

    logic [31:0] r_alu;
    logic [31:0] r_rs2;
    logic [31:0] r_pc4;
    logic        r_memrw;
    logic [1:0]  r_wbsel;
    logic        r_regwen;
    logic [4:0]  r_rsw;
    logic [31:0] r_inst;

`ifdef EX_FWD_EN
    always_comb begin
        case (fwdA_sel_i)
            2'd1:    w_fa = alu_mem_fwd_i;
            2'd2:    w_fa = wb_fwd_i;
            default: w_fa = rs1_ex_i;
        endcase
    end

    always_comb begin
        case (fwdB_sel_i)
            2'd1:    w_fb = alu_mem_fwd_i;
            2'd2:    w_fb = wb_fwd_i;
            default: w_fb = rs2_ex_i;
        endcase
    end
`else
    // Forwarding ports stay on the boundary so both builds share one port list.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{fwdA_sel_i, fwdB_sel_i, alu_mem_fwd_i, wb_fwd_i};
    assign w_fa = rs1_ex_i;
    assign w_fb = rs2_ex_i;
`endif

    assign w_op_a   = ASel_ex_i ? pc_ex_i  : w_fa;
    assign w_op_b   = BSel_ex_i ? imm_ex_i : w_fb;
    assign w_shamt  = w_op_b[4:0];
    assign w_opcode = inst_ex_i[6:0];
    assign w_funct3 = inst_ex_i[14:12];

    always_comb begin
        w_alu = 32'd0;
        case (ALUSel_ex_i)
            ALU_ADD:  w_alu = w_op_a + w_op_b;
            ALU_SUB:  w_alu = w_op_a - w_op_b;
            ALU_SLL:  w_alu = w_op_a << w_shamt;
            ALU_SLT:  w_alu = {31'd0, $signed(w_op_a) < $signed(w_op_b)};
            ALU_SLTU: w_alu = {31'd0, w_op_a < w_op_b};
            ALU_XOR:  w_alu = w_op_a ^ w_op_b;
            ALU_SRL:  w_alu = w_op_a >> w_shamt;
            ALU_SRA:  w_alu = $unsigned($signed(w_op_a) >>> w_shamt);
            ALU_OR:   w_alu = w_op_a | w_op_b;
            ALU_AND:  w_alu = w_op_a & w_op_b;
            ALU_PASB: w_alu = w_op_b;
            default:  w_alu = 32'd0;
        endcase
    end

    // funct3[1] marks LTU/GEU; BrUn additionally turns LT/GE unsigned.
    assign w_lt = (BrUn_ex_i || w_funct3[1]) ? (w_fa < w_fb)
                                             : ($signed(w_fa) < $signed(w_fb));

    always_comb begin
        w_cond = 1'b0;
        case (w_opcode)
            OP_BRANCH: begin
                case (w_funct3)
                    3'b000:         w_cond = (w_fa == w_fb);
                    3'b001:         w_cond = (w_fa != w_fb);
                    3'b100, 3'b110: w_cond = w_lt;
                    3'b101, 3'b111: w_cond = ~w_lt;
                    default:        w_cond = 1'b0;
                endcase
            end
            OP_JAL, OP_JALR: w_cond = 1'b1;
            default:         w_cond = 1'b0;
        endcase
    end

    assign w_jalr_sum  = w_fa + imm_ex_i;
    assign pc_target_o = (w_opcode == OP_JALR) ? {w_jalr_sum[31:1], 1'b0}
                                               : (pc_ex_i + imm_ex_i);

    // enable_i is the pipeline-wide advance: low means hold everything and
    // issue nothing; reset_i only matters while enable_i is high.
    assign w_go                = enable_i & ~reset_i;
    assign br_taken_o          = w_cond & w_go;
    assign mem_if.rd_request_o = (w_opcode == OP_LOAD) & w_go;
    assign mem_if.MemRW_ex_o   = MemRW_ex_i & w_go;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_alu    <= 32'd0;
            r_rs2    <= 32'd0;
            r_pc4    <= 32'd0;
            r_memrw  <= 1'b0;
            r_wbsel  <= 2'd0;
            r_regwen <= 1'b0;
            r_rsw    <= 5'd0;
            r_inst   <= BUBBLE_INST;
        end else if (enable_i) begin
            if (reset_i) begin
                r_alu    <= 32'd0;
                r_rs2    <= 32'd0;
                r_pc4    <= 32'd0;
                r_memrw  <= 1'b0;
                r_wbsel  <= 2'd0;
                r_regwen <= 1'b0;
                r_rsw    <= 5'd0;
                r_inst   <= BUBBLE_INST;
            end else begin
                r_alu    <= w_alu;
                r_rs2    <= w_fb;
                r_pc4    <= pc_ex_i + 32'd4;
                r_memrw  <= MemRW_ex_i;
                r_wbsel  <= WBSel_ex_i;
                r_regwen <= RegWEn_ex_i;
                r_rsw    <= rsW_ex_i;
                r_inst   <= inst_ex_i;
            end
        end
    end

    assign mem_if.alu_mem_o    = r_alu;
    assign mem_if.rs2_mem_o    = r_rs2;
    assign mem_if.pc4_mem_o    = r_pc4;
    assign mem_if.MemRW_mem_o  = r_memrw;
    assign mem_if.WBSel_mem_o  = r_wbsel;
    assign mem_if.RegWEn_mem_o = r_regwen;
    assign mem_if.rsW_mem_o    = r_rsw;
    assign mem_if.inst_mem_o   = r_inst;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized traffic
// against a behavioural reference model and an expected-value queue.
`timescale 1ns/1ps
module tb_ex_stage;
    localparam logic [31:0] BUBBLE = 32'h0000_0013;
`ifdef EX_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        memrw;
        logic [1:0]  wbsel;
        logic        regwen;
        logic [4:0]  rsw;
    } mem_bundle_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        enable_i = 1'b0;
    logic        reset_i = 1'b0;
    logic [31:0] pc_ex_i = '0, rs1_ex_i = '0, rs2_ex_i = '0, imm_ex_i = '0, inst_ex_i = '0;
    logic        ASel_ex_i = 1'b0, BSel_ex_i = 1'b0, BrUn_ex_i = 1'b0, MemRW_ex_i = 1'b0;
    logic [3:0]  ALUSel_ex_i = '0;
    logic [1:0]  WBSel_ex_i = '0;
    logic        RegWEn_ex_i = 1'b0;
    logic [4:0]  rsW_ex_i = '0;
    logic [1:0]  fwdA_sel_i = '0, fwdB_sel_i = '0;
    logic [31:0] alu_mem_fwd_i = '0, wb_fwd_i = '0;
    logic        br_taken_o;
    logic [31:0] pc_target_o;

    ex_stage_if mem_if ();

    ex_stage #(.BUBBLE_INST(BUBBLE), .ALU_SEL_W(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .reset_i(reset_i),
        .pc_ex_i(pc_ex_i), .rs1_ex_i(rs1_ex_i), .rs2_ex_i(rs2_ex_i),
        .imm_ex_i(imm_ex_i), .inst_ex_i(inst_ex_i),
        .ASel_ex_i(ASel_ex_i), .BSel_ex_i(BSel_ex_i), .ALUSel_ex_i(ALUSel_ex_i),
        .BrUn_ex_i(BrUn_ex_i), .MemRW_ex_i(MemRW_ex_i), .WBSel_ex_i(WBSel_ex_i),
        .RegWEn_ex_i(RegWEn_ex_i), .rsW_ex_i(rsW_ex_i),
        .fwdA_sel_i(fwdA_sel_i), .fwdB_sel_i(fwdB_sel_i),
        .alu_mem_fwd_i(alu_mem_fwd_i), .wb_fwd_i(wb_fwd_i),
        .mem_if(mem_if), .br_taken_o(br_taken_o), .pc_target_o(pc_target_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [$bits(mem_bundle_t)-1:0] exp_q[$];
    mem_bundle_t model_q;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] rs,
                                            input logic [31:0] mem_v, input logic [31:0] wb_v);
        if (FWD_ON && sel == 2'd1) return mem_v;
        if (FWD_ON && sel == 2'd2) return wb_v;
        return rs;
    endfunction

    function automatic logic signed_lt(input logic [31:0] a, input logic [31:0] b);
        if (a[31] != b[31]) return a[31];
        return a < b;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ext;
        int sh;
        sh = int'(b[4:0]);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a + (~b) + 32'd1;
            4'd2:  return a << sh;
            4'd3:  return {31'd0, signed_lt(a, b)};
            4'd4:  return {31'd0, a < b};
            4'd5:  return a ^ b;
            4'd6:  return a >> sh;
            4'd7: begin
                ext = {{32{a[31]}}, a} >> sh;
                return ext[31:0];
            end
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic cond_ref(input logic [31:0] inst, input logic brun,
                                      input logic [31:0] fa, input logic [31:0] fb);
        logic ult, slt;
        ult = fa < fb;
        slt = signed_lt(fa, fb);
        if (inst[6:0] == 7'b1101111 || inst[6:0] == 7'b1100111) return 1'b1;
        if (inst[6:0] != 7'b1100011) return 1'b0;
        case (inst[14:12])
            3'b000:  return fa == fb;
            3'b001:  return fa != fb;
            3'b100:  return brun ? ult : slt;
            3'b101:  return brun ? !ult : !slt;
            3'b110:  return ult;
            3'b111:  return !ult;
            default: return 1'b0;
        endcase
    endfunction

    // Check combinational outputs for the current inputs, then clock once
    // and compare the EX/MEM register against the popped expectation.
    task automatic step(input string tag);
        logic [31:0] fa, fb, a, b, tgt;
        logic        go, taken;
        mem_bundle_t nxt, e;
        #1;
        fa = fwd_ref(fwdA_sel_i, rs1_ex_i, alu_mem_fwd_i, wb_fwd_i);
        fb = fwd_ref(fwdB_sel_i, rs2_ex_i, alu_mem_fwd_i, wb_fwd_i);
        a  = ASel_ex_i ? pc_ex_i : fa;
        b  = BSel_ex_i ? imm_ex_i : fb;
        go = enable_i && !reset_i;
        taken = go && cond_ref(inst_ex_i, BrUn_ex_i, fa, fb);
        if (inst_ex_i[6:0] == 7'b1100111) tgt = (fa + imm_ex_i) & 32'hFFFF_FFFE;
        else                              tgt = pc_ex_i + imm_ex_i;
        check_val({tag, ".rd_request"}, 32'(mem_if.rd_request_o),
                  32'(go && inst_ex_i[6:0] == 7'b0000011));
        check_val({tag, ".MemRW_ex"}, 32'(mem_if.MemRW_ex_o), 32'(go && MemRW_ex_i));
        check_val({tag, ".br_taken"}, 32'(br_taken_o), 32'(taken));
        if (taken) check_val({tag, ".pc_target"}, pc_target_o, tgt);

        if (!rst_ni || (enable_i && reset_i)) begin
            nxt = '0;
            nxt.inst = BUBBLE;
        end else if (enable_i) begin
            nxt.alu    = alu_ref(ALUSel_ex_i, a, b);
            nxt.rs2    = fb;
            nxt.pc4    = pc_ex_i + 32'd4;
            nxt.inst   = inst_ex_i;
            nxt.memrw  = MemRW_ex_i;
            nxt.wbsel  = WBSel_ex_i;
            nxt.regwen = RegWEn_ex_i;
            nxt.rsw    = rsW_ex_i;
        end else begin
            nxt = model_q;
        end
        model_q = nxt;
        exp_q.push_back(nxt);

        @(posedge clk_i);
        #1;
        e = mem_bundle_t'(exp_q.pop_front());
        check_val({tag, ".alu_mem"},    mem_if.alu_mem_o,          e.alu);
        check_val({tag, ".rs2_mem"},    mem_if.rs2_mem_o,          e.rs2);
        check_val({tag, ".pc4_mem"},    mem_if.pc4_mem_o,          e.pc4);
        check_val({tag, ".inst_mem"},   mem_if.inst_mem_o,         e.inst);
        check_val({tag, ".MemRW_mem"},  32'(mem_if.MemRW_mem_o),   32'(e.memrw));
        check_val({tag, ".WBSel_mem"},  32'(mem_if.WBSel_mem_o),   32'(e.wbsel));
        check_val({tag, ".RegWEn_mem"}, 32'(mem_if.RegWEn_mem_o),  32'(e.regwen));
        check_val({tag, ".rsW_mem"},    32'(mem_if.rsW_mem_o),     32'(e.rsw));
    endtask

    // ---------------- driver ----------------
    task automatic set_ex(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic [31:0] inst,
                          input logic asel, input logic bsel, input logic [3:0] op,
                          input logic brun, input logic memrw);
        pc_ex_i     = pc;
        rs1_ex_i    = rs1;
        rs2_ex_i    = rs2;
        imm_ex_i    = imm;
        inst_ex_i   = inst;
        ASel_ex_i   = asel;
        BSel_ex_i   = bsel;
        ALUSel_ex_i = op;
        BrUn_ex_i   = brun;
        MemRW_ex_i  = memrw;
        WBSel_ex_i  = 2'($urandom_range(0, 3));
        RegWEn_ex_i = !memrw;
        rsW_ex_i    = 5'($urandom_range(1, 31));
        fwdA_sel_i  = 2'd0;
        fwdB_sel_i  = 2'd0;
    endtask

    function automatic logic [31:0] pick_val();
        logic [31:0] edge_tbl [5];
        edge_tbl = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        if ($urandom_range(0, 2) == 0) return edge_tbl[$urandom_range(0, 4)];
        return $urandom();
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [6:0]  opc_tbl [7];
        logic [31:0] r;
        opc_tbl = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                    7'b1100011, 7'b1101111, 7'b1100111};

        rst_ni = 1'b0;
        step("reset");
        check_val("reset.inst_bubble", mem_if.inst_mem_o, BUBBLE);
        check_val("reset.alu_zero", mem_if.alu_mem_o, 32'd0);
        rst_ni   = 1'b1;
        enable_i = 1'b1;

        set_ex(32'h100, 32'd5, 32'd7, 32'd0, 32'h0000_0033, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        step("add");
        check_val("add.const_alu", mem_if.alu_mem_o, 32'd12);
        check_val("add.const_pc4", mem_if.pc4_mem_o, 32'h104);

        set_ex(32'h200, 32'h8000_0000, 32'd0, 32'd33, 32'h0000_0013, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
        step("sra");
        check_val("sra.const_alu", mem_if.alu_mem_o, 32'hC000_0000);

        set_ex(32'h204, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'h0000_0033, 1'b0, 1'b0, 4'd4, 1'b0, 1'b0);
        step("sltu");
        check_val("sltu.const_alu", mem_if.alu_mem_o, 32'd1);

        set_ex(32'hFFFF_FFFC, 32'd3, 32'd4, 32'd0, 32'h0000_0033, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0);
        step("pc_wrap");
        check_val("pc_wrap.const_pc4", mem_if.pc4_mem_o, 32'd0);

        for (int i = 0; i < 3; i++) begin
            enable_i = 1'b0;
            reset_i  = 1'b1;
            set_ex(32'h300 + 32'(i * 4), pick_val(), pick_val(), 32'd8, 32'h0000_2003 + 32'(i << 20),
                   1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
            if (i == 2) inst_ex_i = 32'h0000_006F;
            step("stall");
            check_val("stall.const_pc4", mem_if.pc4_mem_o, 32'hFFFF_FFFC + 32'd4);
        end

        enable_i = 1'b1;
        reset_i  = 1'b1;
        set_ex(32'h400, 32'h40, 32'h55, 32'd4, 32'h0000_2023, 1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
        step("flush");
        check_val("flush.const_regwen", 32'(mem_if.RegWEn_mem_o), 32'd0);
        check_val("flush.const_inst", mem_if.inst_mem_o, BUBBLE);
        reset_i = 1'b0;

        set_ex(32'h500, 32'd1, 32'hFFFF_FFFF, 32'h40, 32'h0000_6063, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        step("bltu");
        set_ex(32'h500, 32'd1, 32'hFFFF_FFFF, 32'h40, 32'h0000_4063, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        #1;
        check_val("blt.const_taken", 32'(br_taken_o), 32'd0);
        step("blt");
        set_ex(32'h600, 32'h1001, 32'd0, 32'd2, 32'h0000_0067, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0);
        #1;
        check_val("jalr.const_target", pc_target_o, 32'h1002);
        step("jalr");

        set_ex(32'h700, 32'd100, 32'd200, 32'd0, 32'h0000_0033, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        fwdA_sel_i    = 2'd1;
        alu_mem_fwd_i = 32'd9;
        fwdB_sel_i    = 2'd2;
        wb_fwd_i      = 32'd3;
        step("fwd");
        check_val("fwd.const_alu", mem_if.alu_mem_o, FWD_ON ? 32'd12 : 32'd300);
        check_val("fwd.const_rs2", mem_if.rs2_mem_o, FWD_ON ? 32'd3 : 32'd200);

        enable_i = 1'b0;
        set_ex(32'h800, 32'd1, 32'd2, 32'd3, 32'h0000_0033, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
        step("stall2");
        rst_ni = 1'b0;
        step("rst_stall");
        check_val("rst_stall.const_alu", mem_if.alu_mem_o, 32'd0);
        check_val("rst_stall.const_pc4", mem_if.pc4_mem_o, 32'd0);
        check_val("rst_stall.const_inst", mem_if.inst_mem_o, BUBBLE);
        rst_ni = 1'b1;

        for (int i = 0; i < 400; i++) begin
            r = $urandom();
            set_ex(pick_val(), pick_val(), pick_val(), pick_val(),
                   {r[31:7], opc_tbl[$urandom_range(0, 6)]},
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
            fwdA_sel_i    = 2'($urandom_range(0, 3));
            fwdB_sel_i    = 2'($urandom_range(0, 3));
            alu_mem_fwd_i = pick_val();
            wb_fwd_i      = pick_val();
            enable_i      = ($urandom_range(0, 3) != 0);
            reset_i       = ($urandom_range(0, 5) == 0);
            rst_ni        = ($urandom_range(0, 49) != 0);
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
